multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// Multi-cycle RV32I control unit. It sequences each instruction through fetch, decode,
// execute, memory and writeback states, and drives datapath strobes one state at a time.
// It adds load/store, R-type, LUI, JAL and BEQ/BNE/BLT to the single-cycle addi/bne decoder.
// It sits between the instruction register and the register file, ALU, PC and data-memory port.
// PARAMETERS
// INSTR_WIDTH   32  instruction width; decode uses bits [31:0]
// ALUCTRL_WIDTH 3   ALUctrl width: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
// MEM_TIMEOUT   15  max wait cycles for mem_ready in FETCH/MEM; valid range 1..255
// PORTS
// clk        in  1              clock, rising edge
// rst        in  1              asynchronous reset, active-high
// instr      in  INSTR_WIDTH    instruction-register contents, stable from DECODE onward
// EQ         in  1              ALU result zero (rs1==rs2)
// LT         in  1              ALU signed less-than
// mem_ready  in  1              memory handshake: access completes this cycle
// PCWrite    out 1              PC update strobe
// IRWrite    out 1              instruction-register load strobe
// RegWrite   out 1              register-file write strobe
// MemRead    out 1              data/instruction read request
// MemWrite   out 1              store request
// ALUctrl    out ALUCTRL_WIDTH  ALU operation
// ALUsrc     out 1              0 = rs2, 1 = immediate
// ImmSrc     out 3              000 I, 001 S, 010 B, 011 U, 100 J
// PCsrc      out 1              0 = PC+4, 1 = branch/jump target
// ResultSrc  out 2              00 ALU, 01 mem data, 10 PC+4
// fault      out 1              sticky: illegal instruction or memory timeout
// state      out 3              current state, for debug
// BEHAVIOUR
// - Reset (async): state=FETCH, timeout counter=0, fault=0. All strobes are 0 while rst is high.
// - A reset asserted mid-instruction aborts the instruction. No partial write strobe is issued.
// - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Outputs are decoded from state plus registered opcode/funct fields.
// - FETCH: MemRead=1.
//   - On mem_ready: IRWrite=1 for that cycle, then go to DECODE.
// - DECODE: register opcode/funct3/funct7[5], set ImmSrc, then branch on opcode:
//   - OP-IMM (0010011), OP (0110011), LUI (0110111), JAL (1101111), BRANCH (1100011) -> EXEC
//   - LOAD (0000011, funct3=010) or STORE (0100011, funct3=010) -> MEM
//   - anything else, including unsupported funct3 -> HALT with fault=1
// - EXEC:
//   - ALU ops: ALUctrl from funct3 (000 add, or sub if OP && funct7[5]; 111 and; 110 or; 010 slt; 100 xor). ALUsrc=1 for OP-IMM/LUI. Then go to WB.
//   - BRANCH: ALUctrl=001. taken = (f3=000 & EQ) | (f3=001 & !EQ) | (f3=100 & LT). PCWrite=1, PCsrc=taken. Then go to FETCH.
//   - JAL: go to WB.
// - MEM: ALUctrl=000, ALUsrc=1. MemRead (load) or MemWrite (store) held until mem_ready.
//   - Load: on mem_ready go to WB.
//   - Store: on mem_ready assert PCWrite=1, PCsrc=0, and go to FETCH.
// - WB: RegWrite=1 and PCWrite=1, both for one cycle. Then go to FETCH.
//   - ResultSrc: 01 for load, 10 for JAL, else 00.
//   - PCsrc=1 only for JAL.
// - Timeout: counter increments each FETCH/MEM cycle with mem_ready=0. It clears on mem_ready or on state change.
//   - At count == MEM_TIMEOUT: go to HALT with fault=1.
// - HALT: all strobes 0. Stays in HALT until rst.
// - PCWrite is asserted in exactly one cycle per retired instruction.
// - RegWrite is never asserted together with MemWrite.
// - Latency with zero-wait memory:
//   - ALU/JAL: 4 cycles
//   - branch: 3 cycles
//   - load: 4 cycles
//   - store: 3 cycles
// TESTING
// - addi x1,x0,5 (0x00500093), mem_ready=1 -> states 0,1,2,4; RegWrite+PCWrite on cycle 4; ALUsrc=1, ALUctrl=000.
// - bne (0x00209463): EQ=0 -> PCWrite=1, PCsrc=1 in EXEC; EQ=1 -> PCsrc=0; RegWrite never asserted.
// - lw (0x0000A183), mem_ready low for 3 cycles in MEM -> MemRead held 4 cycles, then WB with ResultSrc=01.
// - sw (0x0030A223) -> ImmSrc=001, MemWrite until mem_ready, PCWrite in the same cycle, no RegWrite.
// - 0xFFFFFFFF, or mem_ready stuck low for 15 FETCH cycles -> HALT, fault=1; rst clears both.
// - rst pulsed during MEM of a store -> state=0 immediately, MemWrite=0, fault=0; the next fetch proceeds normally.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control-unit <-> datapath bundle: instruction/flag/handshake inputs and datapath strobes.
// master = control unit (drives strobes), slave = datapath/memory side.
interface multicycle_control_fsm_if #(
  parameter int INSTR_WIDTH   = 32,
  parameter int ALUCTRL_WIDTH = 3
);
  logic [INSTR_WIDTH-1:0]   instr;
  logic                     EQ;
  logic                     LT;
  logic                     mem_ready;
  logic                     PCWrite;
  logic                     IRWrite;
  logic                     RegWrite;
  logic                     MemRead;
  logic                     MemWrite;
  logic [ALUCTRL_WIDTH-1:0] ALUctrl;
  logic                     ALUsrc;
  logic [2:0]               ImmSrc;
  logic                     PCsrc;
  logic [1:0]               ResultSrc;
  logic                     fault;
  logic [2:0]               state;

  // Memory handshake: MemRead/MemWrite is a request held high; the access
  // completes in the cycle where mem_ready is sampled high alongside it.
  modport master (
    input  instr, EQ, LT, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
    output ALUctrl, ALUsrc, ImmSrc, PCsrc, ResultSrc, fault, state
  );

  modport slave (
    output instr, EQ, LT, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
    input  ALUctrl, ALUsrc, ImmSrc, PCsrc, ResultSrc, fault, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory-wait timeout and a sticky fault that parks the machine in HALT.
module multicycle_control_fsm #(
  parameter int INSTR_WIDTH   = 32,
  parameter int ALUCTRL_WIDTH = 3,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_fsm_if.master bus
);

  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5
  } state_t;

  state_t                 state, state_next;
  logic [6:0]             opcode_q;
  logic [2:0]             funct3_q;
  logic                   f7b5_q;
  logic [7:0]             wait_cnt;
  logic                   fault_q;
  logic [INSTR_WIDTH-1:0] ir;
  logic                   unused_bits;
  logic                   wait_cycle, timeout_hit, taken;
  logic                   pc_write, ir_write, reg_write, mem_read, mem_write;
  logic                   alu_src, pc_src;
  logic [2:0]             alu, imm_src;
  logic [1:0]             result_src;

  assign ir          = bus.instr;
  assign unused_bits = ^{ir[INSTR_WIDTH-1:31], ir[29:15], ir[11:7]};

  function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OPC_IMM, OPC_OP:     legal = f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
      OPC_LUI, OPC_JAL:    legal = 1'b1;
      OPC_BRANCH:          legal = f3 inside {3'b000, 3'b001, 3'b100};
      OPC_LOAD, OPC_STORE: legal = (f3 == 3'b010);
      default:             legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OPC_STORE:  imm_sel = 3'b001;
      OPC_BRANCH: imm_sel = 3'b010;
      OPC_LUI:    imm_sel = 3'b011;
      OPC_JAL:    imm_sel = 3'b100;
      default:    imm_sel = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] alu_sel(input logic is_op, input logic [2:0] f3, input logic f7b5);
    case (f3)
      3'b000:  alu_sel = (is_op && f7b5) ? 3'b001 : 3'b000;
      3'b111:  alu_sel = 3'b010;
      3'b110:  alu_sel = 3'b011;
      3'b010:  alu_sel = 3'b100;
      3'b100:  alu_sel = 3'b101;
      default: alu_sel = 3'b000;
    endcase
  endfunction

  // timeout_hit marks the waiting cycle that brings the count up to MEM_TIMEOUT,
  // so MEM_TIMEOUT unanswered cycles are the most FETCH or MEM ever waits.
  assign wait_cycle  = (state == FETCH || state == MEM) && !bus.mem_ready;
  assign timeout_hit = wait_cycle && (wait_cnt == 8'(MEM_TIMEOUT - 1));
  assign taken       = ((funct3_q == 3'b000) && bus.EQ) ||
                       ((funct3_q == 3'b001) && !bus.EQ) ||
                       ((funct3_q == 3'b100) && bus.LT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      opcode_q <= 7'd0;
      funct3_q <= 3'd0;
      f7b5_q   <= 1'b0;
      wait_cnt <= 8'd0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) begin
        opcode_q <= ir[6:0];
        funct3_q <= ir[14:12];
        f7b5_q   <= ir[30];
      end
      if (wait_cycle && state_next == state) wait_cnt <= wait_cnt + 8'd1;
      else                                   wait_cnt <= 8'd0;
      // HALT is only ever entered on a fault, so entry sets the sticky flag.
      if (state_next == HALT && state != HALT) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (bus.mem_ready)    state_next = DECODE;
        else if (timeout_hit) state_next = HALT;
      end
      DECODE: begin
        if (!legal(ir[6:0], ir[14:12]))                      state_next = HALT;
        else if (ir[6:0] == OPC_LOAD || ir[6:0] == OPC_STORE) state_next = MEM;
        else                                                  state_next = EXEC;
      end
      EXEC:    state_next = (opcode_q == OPC_BRANCH) ? FETCH : WB;
      MEM: begin
        if (bus.mem_ready)    state_next = (opcode_q == OPC_LOAD) ? WB : FETCH;
        else if (timeout_hit) state_next = HALT;
      end
      WB:      state_next = FETCH;
      default: state_next = HALT;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu        = 3'b000;
    alu_src    = 1'b0;
    imm_src    = imm_sel(opcode_q);
    pc_src     = 1'b0;
    result_src = 2'b00;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = bus.mem_ready;
        imm_src  = 3'b000;
      end
      DECODE: imm_src = imm_sel(ir[6:0]);
      EXEC: begin
        if (opcode_q == OPC_BRANCH) begin
          alu      = 3'b001;
          pc_write = 1'b1;
          pc_src   = taken;
        end else if (opcode_q == OPC_OP || opcode_q == OPC_IMM) begin
          alu = alu_sel(opcode_q == OPC_OP, funct3_q, f7b5_q);
        end
        alu_src = (opcode_q == OPC_IMM || opcode_q == OPC_LUI);
      end
      MEM: begin
        alu_src = 1'b1;
        if (opcode_q == OPC_LOAD) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
          pc_write  = bus.mem_ready;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        pc_src     = (opcode_q == OPC_JAL);
        result_src = (opcode_q == OPC_LOAD) ? 2'b01 :
                     (opcode_q == OPC_JAL)  ? 2'b10 : 2'b00;
      end
      default: imm_src = 3'b000;
    endcase
  end

  // Reset parks the FSM in FETCH immediately; gating keeps every strobe quiet
  // for as long as rst is held, so an aborted instruction leaves no write behind.
  assign bus.PCWrite   = pc_write  & ~rst;
  assign bus.IRWrite   = ir_write  & ~rst;
  assign bus.RegWrite  = reg_write & ~rst;
  assign bus.MemRead   = mem_read  & ~rst;
  assign bus.MemWrite  = mem_write & ~rst;
  assign bus.ALUctrl   = ALUCTRL_WIDTH'(alu);
  assign bus.ALUsrc    = alu_src;
  assign bus.ImmSrc    = imm_src;
  assign bus.PCsrc     = pc_src;
  assign bus.ResultSrc = result_src;
  assign bus.fault     = fault_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: a table of single instructions with zero-wait
// memory, then hand-written sequences for wait states, timeout, illegal op and reset.
module tb_multicycle_control_fsm;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic        eq;
    logic        lt;
    int          cycles;
    logic [2:0]  imm;
    logic [2:0]  alu;
    logic        alusrc;
    logic        pcsrc;
    logic [1:0]  res;
    int          rw;
    int          mw;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int          cycles = 0, irw = 0, pcw = 0, rw = 0, mw = 0;
    logic [2:0]  imm = 3'd0, alu = 3'd0;
    logic        alusrc = 1'b0, pcsrc = 1'b0, done = 1'b0;
    logic [1:0]  res = 2'd0;
    bus.instr     = vecs[i].instr;
    bus.EQ        = vecs[i].eq;
    bus.LT        = vecs[i].lt;
    bus.mem_ready = 1'b1;
    while (!done && cycles < 8) begin
      #1;
      if (bus.IRWrite) irw++;
      if (bus.state == 3'd1) imm = bus.ImmSrc;
      if (bus.state == 3'd2 || bus.state == 3'd3) begin
        alu    = bus.ALUctrl;
        alusrc = bus.ALUsrc;
      end
      if (bus.PCWrite) begin
        pcw++;
        pcsrc = bus.PCsrc;
      end
      if (bus.RegWrite) begin
        rw++;
        res = bus.ResultSrc;
      end
      if (bus.MemWrite) mw++;
      cycles++;
      tick();
      if (bus.state == 3'd0 || bus.state == 3'd5) done = 1'b1;
    end
    check("back_to_fetch", i, bus.state, 3'd0);
    check("latency", i, cycles, vecs[i].cycles);
    check("irwrite_cnt", i, irw, 1);
    check("pcwrite_cnt", i, pcw, 1);
    check("regwrite_cnt", i, rw, vecs[i].rw);
    check("memwrite_cnt", i, mw, vecs[i].mw);
    check("immsrc", i, imm, vecs[i].imm);
    check("aluctrl", i, alu, vecs[i].alu);
    check("alusrc", i, alusrc, vecs[i].alusrc);
    check("pcsrc", i, pcsrc, vecs[i].pcsrc);
    check("resultsrc", i, res, vecs[i].res);
    check("fault", i, bus.fault, 1'b0);
  endtask

  task automatic run_illegal(input int id, input logic [31:0] ins);
    bus.instr     = ins;
    bus.mem_ready = 1'b1;
    tick();
    check("illegal_decode_state", id, bus.state, 3'd1);
    tick();
    check("illegal_halt_state", id, bus.state, 3'd5);
    check("illegal_fault", id, bus.fault, 1'b1);
    tick();
    tick();
    #1;
    check("halt_sticky_state", id, bus.state, 3'd5);
    check("halt_strobes", id, {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead, bus.MemWrite}, 5'd0);
    rst = 1'b1;
    #1;
    check("halt_rst_state", id, bus.state, 3'd0);
    check("halt_rst_fault", id, bus.fault, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //               instr          eq    lt    cyc imm     alu     src   pcsrc res    rw mw
    vecs[0]  = '{32'h00500093, 1'b0, 1'b0, 4, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00, 1, 0}; // addi
    vecs[1]  = '{32'h402081B3, 1'b0, 1'b0, 4, 3'b000, 3'b001, 1'b0, 1'b0, 2'b00, 1, 0}; // sub
    vecs[2]  = '{32'h0020F1B3, 1'b0, 1'b0, 4, 3'b000, 3'b010, 1'b0, 1'b0, 2'b00, 1, 0}; // and
    vecs[3]  = '{32'h0020E1B3, 1'b0, 1'b0, 4, 3'b000, 3'b011, 1'b0, 1'b0, 2'b00, 1, 0}; // or
    vecs[4]  = '{32'h0020A193, 1'b0, 1'b0, 4, 3'b000, 3'b100, 1'b1, 1'b0, 2'b00, 1, 0}; // slti
    vecs[5]  = '{32'h0020C193, 1'b0, 1'b0, 4, 3'b000, 3'b101, 1'b1, 1'b0, 2'b00, 1, 0}; // xori
    vecs[6]  = '{32'h000010B7, 1'b0, 1'b0, 4, 3'b011, 3'b000, 1'b1, 1'b0, 2'b00, 1, 0}; // lui
    vecs[7]  = '{32'h008000EF, 1'b0, 1'b0, 4, 3'b100, 3'b000, 1'b0, 1'b1, 2'b10, 1, 0}; // jal
    vecs[8]  = '{32'h00209463, 1'b0, 1'b0, 3, 3'b010, 3'b001, 1'b0, 1'b1, 2'b00, 0, 0}; // bne taken
    vecs[9]  = '{32'h00209463, 1'b1, 1'b0, 3, 3'b010, 3'b001, 1'b0, 1'b0, 2'b00, 0, 0}; // bne not taken
    vecs[10] = '{32'h00208463, 1'b1, 1'b0, 3, 3'b010, 3'b001, 1'b0, 1'b1, 2'b00, 0, 0}; // beq taken
    vecs[11] = '{32'h0020C463, 1'b0, 1'b1, 3, 3'b010, 3'b001, 1'b0, 1'b1, 2'b00, 0, 0}; // blt taken
    vecs[12] = '{32'h0020C463, 1'b1, 1'b0, 3, 3'b010, 3'b001, 1'b0, 1'b0, 2'b00, 0, 0}; // blt not taken
    vecs[13] = '{32'h0000A183, 1'b0, 1'b0, 4, 3'b000, 3'b000, 1'b1, 1'b0, 2'b01, 1, 0}; // lw
    vecs[14] = '{32'h0030A223, 1'b0, 1'b0, 3, 3'b001, 3'b000, 1'b1, 1'b0, 2'b00, 0, 1}; // sw

    rst           = 1'b1;
    bus.instr     = 32'h0;
    bus.EQ        = 1'b0;
    bus.LT        = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("reset_state", 0, bus.state, 3'd0);
    check("reset_fault", 0, bus.fault, 1'b0);
    check("reset_strobes", 0, {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead, bus.MemWrite}, 5'd0);
    rst = 1'b0;
    #1;
    check("fetch_memread", 0, bus.MemRead, 1'b1);

    for (int i = 0; i < 15; i++) run_vec(i);

    // lw with three wait cycles in MEM
    begin
      logic       ready_seq[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0] state_seq[7] = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
      int         mem_reads = 0;
      bus.instr = 32'h0000A183;
      for (int c = 0; c < 7; c++) begin
        bus.mem_ready = ready_seq[c];
        #1;
        check("lw_wait_state", c, bus.state, state_seq[c]);
        if (bus.state == 3'd3 && bus.MemRead) mem_reads++;
        if (c == 6) begin
          check("lw_wait_resultsrc", c, bus.ResultSrc, 2'b01);
          check("lw_wait_regwrite", c, {bus.RegWrite, bus.PCWrite}, 2'b11);
        end else begin
          check("lw_wait_no_pcwrite", c, bus.PCWrite, 1'b0);
        end
        tick();
      end
      check("lw_wait_memread_cycles", 0, mem_reads, 4);
      check("lw_wait_back_to_fetch", 0, bus.state, 3'd0);
    end

    // sw waiting one cycle: MemWrite held, PCWrite only in the completing cycle
    bus.instr     = 32'h0030A223;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("sw_wait_memwrite", 0, {bus.MemWrite, bus.PCWrite, bus.RegWrite}, 3'b100);
    check("sw_wait_immsrc", 0, bus.ImmSrc, 3'b001);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    check("sw_done_strobes", 0, {bus.MemWrite, bus.PCWrite, bus.PCsrc, bus.RegWrite}, 4'b1100);
    tick();
    check("sw_done_state", 0, bus.state, 3'd0);

    run_illegal(0, 32'hFFFFFFFF);
    run_illegal(1, 32'h00009183); // lh: unsupported load width

    // FETCH timeout: 14 unanswered cycles keep waiting, the 15th halts
    bus.mem_ready = 1'b0;
    for (int c = 0; c < 14; c++) tick();
    check("timeout_still_fetch", 0, bus.state, 3'd0);
    check("timeout_no_fault_yet", 0, bus.fault, 1'b0);
    tick();
    check("timeout_halt", 0, bus.state, 3'd5);
    check("timeout_fault", 0, bus.fault, 1'b1);
    bus.mem_ready = 1'b1;
    tick();
    #1;
    check("timeout_halt_held", 0, {bus.state, bus.MemRead}, {3'd5, 1'b0});
    pulse_reset();
    check("timeout_rst_clear", 0, {bus.state, bus.fault}, {3'd0, 1'b0});

    // reset asserted during MEM of a store
    bus.instr     = 32'h0030A223;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("sw_abort_in_mem", 0, {bus.state, bus.MemWrite}, {3'd3, 1'b1});
    rst = 1'b1;
    #1;
    check("sw_abort_state", 0, bus.state, 3'd0);
    check("sw_abort_strobes", 0, {bus.MemWrite, bus.PCWrite, bus.RegWrite}, 3'b000);
    check("sw_abort_fault", 0, bus.fault, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
